// File: rtl/sram_access_arbiter.sv
// Two-port arbiter sharing one fixed-wait-state SRAM between port A (mem stage) and port B (fetch).
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port A wins every tie.
module sram_access_arbiter #(
   parameter int          WAIT_CYCLES = 5,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_rd_en,
   input  logic        a_wr_en,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic [31:0] a_rdata,
   output logic        a_ready,
   input  logic        b_rd_en,
   input  logic        b_wr_en,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic [31:0] b_rdata,
   output logic        b_ready,
   output logic        SRAM_WE_N,
   output logic [16:0] SRAM_ADDR,
   inout  wire  [31:0] SRAM_DQ
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   logic        grant_b;
   logic        is_wr;
   logic [31:0] wdata_q;
   logic [3:0]  cnt;
   logic        a_req, b_req, pick_b, wr_drive;
   logic [31:0] sel_addr;

   assign a_req = a_rd_en | a_wr_en;
   assign b_req = b_rd_en | b_wr_en;

`ifdef SRAM_ARB_RR_EN
   logic rr_b;  // port favoured on the next tie
   assign pick_b = b_req & (~a_req | rr_b);
`else
   assign pick_b = b_req & ~a_req;
`endif

   assign sel_addr = pick_b ? b_addr : a_addr;

   // Pins are released in the very cycle reset is seen, not one edge later.
   assign wr_drive  = (state == ACCESS) & is_wr & ~rst;
   assign SRAM_WE_N = ~wr_drive;
   assign SRAM_DQ   = wr_drive ? wdata_q : 32'hzzzz_zzzz;

   assign a_ready = ~a_req | ((state == DONE) & ~grant_b);
   assign b_ready = ~b_req | ((state == DONE) &  grant_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_b   <= 1'b0;
         is_wr     <= 1'b0;
         wdata_q   <= '0;
         cnt       <= '0;
         SRAM_ADDR <= '0;
         a_rdata   <= '0;
         b_rdata   <= '0;
`ifdef SRAM_ARB_RR_EN
         rr_b      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (a_req | b_req) begin
                  grant_b   <= pick_b;
                  is_wr     <= pick_b ? b_wr_en : a_wr_en;
                  wdata_q   <= pick_b ? b_wdata : a_wdata;
                  SRAM_ADDR <= 17'((sel_addr - BASE_ADDR) >> 2);
                  cnt       <= 4'(WAIT_CYCLES - 1);
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  if (!is_wr) begin
                     if (grant_b) b_rdata <= SRAM_DQ;
                     else         a_rdata <= SRAM_DQ;
                  end
`ifdef SRAM_ARB_RR_EN
                  rr_b <= ~grant_b;
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized and directed bench for sram_access_arbiter against a transaction-level reference model.
module tb_sram_access_arbiter;

   localparam int W  = 5;
   localparam int W2 = 1;
`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_rd_en = 0, a_wr_en = 0, b_rd_en = 0, b_wr_en = 0;
   logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
   logic [31:0] a_rdata, b_rdata;
   logic        a_ready, b_ready, sram_we_n;
   logic [16:0] sram_addr;
   wire  [31:0] dq;

   logic        a2_rd_en = 0;
   logic        zero = 1'b0;
   logic [31:0] a2_addr = 0, zero32 = 0;
   logic [31:0] a2_rdata, b2_rdata;
   logic        a2_ready, b2_ready, sram_we_n2;
   logic [16:0] sram_addr2;
   wire  [31:0] dq2;

   int checks = 0, failures = 0;
   int wr_count = 0;
   bit mem_init = 1'b0;
   bit favor_b = 1'b0;
   logic [31:0] exp_rd_a = 0, exp_rd_b = 0;
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];

   always #5 clk = ~clk;

   sram_access_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst),
      .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_ready(a_ready),
      .b_rd_en(b_rd_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_ready(b_ready),
      .SRAM_WE_N(sram_we_n), .SRAM_ADDR(sram_addr), .SRAM_DQ(dq));

   sram_access_arbiter #(.WAIT_CYCLES(W2), .BASE_ADDR(32'd1024)) dut2 (
      .clk(clk), .rst(rst),
      .a_rd_en(a2_rd_en), .a_wr_en(zero), .a_addr(a2_addr), .a_wdata(zero32),
      .a_rdata(a2_rdata), .a_ready(a2_ready),
      .b_rd_en(zero), .b_wr_en(zero), .b_addr(zero32), .b_wdata(zero32),
      .b_rdata(b2_rdata), .b_ready(b2_ready),
      .SRAM_WE_N(sram_we_n2), .SRAM_ADDR(sram_addr2), .SRAM_DQ(dq2));

   // SRAM pin models: drive the bus whenever the controller is not writing.
   assign dq  = sram_we_n  ? mem[sram_addr[7:0]] : 32'hzzzz_zzzz;
   assign dq2 = sram_we_n2 ? (32'hC0DE_0000 | {15'h0, sram_addr2}) : 32'hzzzz_zzzz;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h5000_0000 + i * 32'h0101;
      end else if (!sram_we_n) begin
         mem[sram_addr[7:0]] <= dq;
         wr_count <= wr_count + 1;
      end
   end

   function automatic logic [16:0] word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - 32'd1024;
      return off[18:2];
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // op: 0 none, 1 read, 2 write, 3 read+write (counts as write)
   task automatic run_pair(input int aop, input logic [31:0] aad, input logic [31:0] adat,
                           input int bop, input logic [31:0] bad, input logic [31:0] bdat);
      bit areq, breq, a_first, pa, pb, port_b;
      int lat_a, lat_b, we_low, nwr, dq_bad, k, op;
      logic [16:0] first_word;
      logic [31:0] wd [2];
      logic [31:0] ad, dt;
      areq = (aop != 0); breq = (bop != 0);
      if (areq && breq) a_first = RR ? !favor_b : 1'b1;
      else              a_first = areq;
      lat_a = -1; lat_b = -1; nwr = 0; k = 0; first_word = 0; wd[0] = 0; wd[1] = 0;
      for (int s = 0; s < 2; s++) begin
         port_b = (s == 0) ? !a_first : a_first;
         if (port_b ? breq : areq) begin
            op = port_b ? bop : aop;
            ad = port_b ? bad : aad;
            dt = port_b ? bdat : adat;
            if (k == 0) first_word = word_of(ad);
            wd[k] = dt;
            if (port_b) lat_b = (k == 0) ? W + 1 : 2 * W + 3;
            else        lat_a = (k == 0) ? W + 1 : 2 * W + 3;
            if (op >= 2) begin
               ref_mem[word_of(ad) & 17'hFF] = dt;
               nwr++;
            end else if (port_b) exp_rd_b = ref_mem[word_of(ad) & 17'hFF];
            else                 exp_rd_a = ref_mem[word_of(ad) & 17'hFF];
            favor_b = !port_b;
            k++;
         end
      end
      step();
      a_rd_en = (aop == 1 || aop == 3); a_wr_en = (aop >= 2); a_addr = aad; a_wdata = adat;
      b_rd_en = (bop == 1 || bop == 3); b_wr_en = (bop >= 2); b_addr = bad; b_wdata = bdat;
      pa = areq; pb = breq; we_low = 0; dq_bad = 0;
      for (int n = 0; n < 4 * W + 10 && (pa || pb); n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++;
            if (sram_addr !== first_word) begin
               failures++; $display("FAIL sram_addr got=%0h exp=%0h", sram_addr, first_word);
            end
         end
         if (!sram_we_n) begin
            we_low++;
            if (dq !== ((n <= W + 1) ? wd[0] : wd[1])) dq_bad++;
         end else if (dq !== mem[sram_addr[7:0]]) dq_bad++;
         if (pa && a_ready) begin
            checks += 2;
            if (n != lat_a) begin failures++; $display("FAIL a_latency got=%0d exp=%0d", n, lat_a); end
            if (a_rdata !== exp_rd_a) begin failures++; $display("FAIL a_rdata got=%h exp=%h", a_rdata, exp_rd_a); end
            pa = 0;
         end
         if (pb && b_ready) begin
            checks += 2;
            if (n != lat_b) begin failures++; $display("FAIL b_latency got=%0d exp=%0d", n, lat_b); end
            if (b_rdata !== exp_rd_b) begin failures++; $display("FAIL b_rdata got=%h exp=%h", b_rdata, exp_rd_b); end
            pb = 0;
         end
         if (!areq && !a_ready) begin checks++; failures++; $display("FAIL a_idle_ready got=0 exp=1"); end
         if (!breq && !b_ready) begin checks++; failures++; $display("FAIL b_idle_ready got=0 exp=1"); end
         step();
         if (!pa) begin a_rd_en = 0; a_wr_en = 0; end
         if (!pb) begin b_rd_en = 0; b_wr_en = 0; end
      end
      checks += 3;
      if (pa || pb) begin
         failures++; $display("FAIL ready_timeout got=pending exp=done");
         a_rd_en = 0; a_wr_en = 0; b_rd_en = 0; b_wr_en = 0;
      end
      if (we_low != W * nwr) begin failures++; $display("FAIL we_n_low_cycles got=%0d exp=%0d", we_low, W * nwr); end
      if (dq_bad != 0) begin failures++; $display("FAIL dq_bus got=%0d bad cycles exp=0", dq_bad); end
   endtask

   task automatic test_reset();
      rst = 1; mem_init = 1;
      step();
      mem_init = 0;
      step();
      @(negedge clk);
      checks += 4;
      if (sram_we_n !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%b exp=1", sram_we_n); end
      if ({a_ready, b_ready, b2_ready} !== 3'b111) begin failures++; $display("FAIL rst_ready got=%b exp=111", {a_ready, b_ready, b2_ready}); end
      if ({a_rdata, b_rdata, a2_rdata} !== 96'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", {a_rdata, b_rdata, a2_rdata}); end
      if (sram_addr !== 17'h0 || dq !== mem[0]) begin failures++; $display("FAIL rst_pins got=%h/%h exp=0/%h", sram_addr, dq, mem[0]); end
      step();
      rst = 0;
   endtask

   task automatic test_write_read();
      run_pair(2, 32'd1024, 32'hDEADBEEF, 0, 0, 0);
      run_pair(1, 32'd1024, 32'h0, 0, 0, 0);
      checks++;
      if (a_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_read got=%h exp=deadbeef", a_rdata); end
      run_pair(2, 32'd1036, 32'h1234_5678, 0, 0, 0);
      checks++;
      if (a_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rdata_hold_on_write got=%h exp=deadbeef", a_rdata); end
      run_pair(3, 32'd1020, 32'hCAFE_F00D, 1, 32'd1020, 0);   // below base wraps to word 0x1FFFF
   endtask

   task automatic test_tie();
      run_pair(1, 32'd1028, 0, 1, 32'd1032, 0);
      run_pair(0, 0, 0, 1, 32'd1024, 0);
   endtask

   task automatic test_random();
      int aop, bop;
      logic [31:0] aad, bad;
      for (int it = 0; it < 14; it++) begin
         aop = $urandom_range(0, 3); bop = $urandom_range(0, 3);
         aad = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         bad = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         run_pair(aop, aad, $urandom, bop, bad, $urandom);
      end
   endtask

   task automatic test_contention();
      int served, exp_cyc, last_a, last_b;
      bit exp_b;
      logic [31:0] e;
      served = 0; exp_cyc = W + 1; last_a = 0; last_b = 0;
      step();
      a_rd_en = 1; a_addr = 32'd1024 + 4 * 3; b_rd_en = 1; b_addr = 32'd1024 + 4 * 5;
      for (int n = 0; n < 200 && served < 6; n++) begin
         @(negedge clk);
         if (a_ready || b_ready) begin
            exp_b = RR ? favor_b : 1'b0;
            e = exp_b ? ref_mem[5] : ref_mem[3];
            checks += 3;
            if (a_ready === b_ready || b_ready !== exp_b) begin
               failures++; $display("FAIL contention_grant got=%b%b exp_b=%b", a_ready, b_ready, exp_b);
            end
            if (n != exp_cyc) begin failures++; $display("FAIL contention_cycle got=%0d exp=%0d", n, exp_cyc); end
            if ((exp_b ? b_rdata : a_rdata) !== e) begin failures++; $display("FAIL contention_rdata exp=%h", e); end
            if (RR) begin
               checks++;
               if (n - (exp_b ? last_b : last_a) > 2 * (W + 2)) begin
                  failures++; $display("FAIL rr_gap got=%0d exp<=%0d", n - (exp_b ? last_b : last_a), 2 * (W + 2));
               end
            end
            if (exp_b) begin last_b = n; exp_rd_b = e; end
            else       begin last_a = n; exp_rd_a = e; end
            favor_b = !exp_b; served++; exp_cyc += W + 2;
         end
         step();
      end
      a_rd_en = 0; b_rd_en = 0;
      checks++;
      if (served != 6) begin failures++; $display("FAIL contention_timeout got=%0d exp=6", served); end
   endtask

   task automatic test_reset_mid_write();
      int wc0, bad;
      logic [31:0] dat;
      dat = 32'hA5A5_0F0F;
      step();
      wc0 = wr_count;
      a_wr_en = 1; a_addr = 32'd1024 + 4 * 9; a_wdata = dat;
      step(); step(); step();        // now in the third ACCESS cycle
      rst = 1;
      @(negedge clk);
      checks++;
      if (sram_we_n !== 1'b1 || dq !== mem[sram_addr[7:0]]) begin
         failures++; $display("FAIL rst_mid_release got=we_n %b dq %h exp=we_n 1", sram_we_n, dq);
      end
      step();
      rst = 0; a_wr_en = 0;
      bad = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (sram_we_n !== 1'b1 || a_ready !== 1'b1) bad++;
      end
      checks += 2;
      if (bad != 0) begin failures++; $display("FAIL rst_mid_idle got=%0d bad cycles exp=0", bad); end
      if (wr_count - wc0 != 2) begin failures++; $display("FAIL rst_mid_writes got=%0d exp=2", wr_count - wc0); end
      ref_mem[9] = dat; exp_rd_a = 0; exp_rd_b = 0; favor_b = 0;
      run_pair(1, 32'd1024 + 4 * 9, 0, 0, 0, 0);
   endtask

   task automatic test_wait1();
      int bad;
      bit done;
      logic [31:0] e;
      e = 32'hC0DE_0000 + ((32'd1032 - 32'd1024) >> 2);
      bad = 0; done = 0;
      step();
      a2_rd_en = 1; a2_addr = 32'd1032;
      for (int n = 0; n < 6 && !done; n++) begin
         @(negedge clk);
         if (b2_ready !== 1'b1) bad++;
         if (a2_ready) begin
            done = 1;
            checks += 2;
            if (n != 2) begin failures++; $display("FAIL w1_latency got=%0d exp=2", n); end
            if (a2_rdata !== e) begin failures++; $display("FAIL w1_rdata got=%h exp=%h", a2_rdata, e); end
         end
         step();
      end
      a2_rd_en = 0;
      checks += 2;
      if (!done) begin failures++; $display("FAIL w1_timeout got=pending exp=done"); end
      if (bad != 0) begin failures++; $display("FAIL w1_b_ready got=%0d low cycles exp=0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h5000_0000 + i * 32'h0101;
      test_reset();
      test_write_read();
      test_tie();
      test_random();
      test_contention();
      test_reset_mid_write();
      test_wait1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
